// File: rtl/raster_pkg.sv
// Shared types and helpers for the triangle scan controller.
package raster_pkg;

  localparam int COORD_W      = 11;
  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BBOX = 2'd1,
    SCAN = 2'd2
  } scan_state_t;

  typedef struct packed {
    logic signed [COORD_W-1:0] x;
    logic signed [COORD_W-1:0] y;
  } vertex_t;

  function automatic logic signed [COORD_W-1:0] min3(
    input logic signed [COORD_W-1:0] a,
    input logic signed [COORD_W-1:0] b,
    input logic signed [COORD_W-1:0] c
  );
    logic signed [COORD_W-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [COORD_W-1:0] max3(
    input logic signed [COORD_W-1:0] a,
    input logic signed [COORD_W-1:0] b,
    input logic signed [COORD_W-1:0] c
  );
    logic signed [COORD_W-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

endpackage

// File: rtl/bbox_clip.sv
// Combinational bounding box of three vertices, clipped to the screen.
module bbox_clip
  import raster_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic signed [COORD_W-1:0] v1_x,
  input  logic signed [COORD_W-1:0] v1_y,
  input  logic signed [COORD_W-1:0] v2_x,
  input  logic signed [COORD_W-1:0] v2_y,
  input  logic signed [COORD_W-1:0] v3_x,
  input  logic signed [COORD_W-1:0] v3_y,
  output logic signed [COORD_W-1:0] xmin,
  output logic signed [COORD_W-1:0] xmax,
  output logic signed [COORD_W-1:0] ymin,
  output logic signed [COORD_W-1:0] ymax,
  output logic                      empty
);

  localparam logic signed [COORD_W-1:0] ZERO = '0;
  localparam logic signed [COORD_W-1:0] X_HI = COORD_W'(SCREEN_W - 1);
  localparam logic signed [COORD_W-1:0] Y_HI = COORD_W'(SCREEN_H - 1);

  logic signed [COORD_W-1:0] raw_xmin, raw_xmax, raw_ymin, raw_ymax;

  // Min/max over the vertices, then clamp to the visible area; an inverted box means fully off-screen
  always_comb begin
    raw_xmin = min3(v1_x, v2_x, v3_x);
    raw_xmax = max3(v1_x, v2_x, v3_x);
    raw_ymin = min3(v1_y, v2_y, v3_y);
    raw_ymax = max3(v1_y, v2_y, v3_y);
    xmin  = (raw_xmin < ZERO) ? ZERO : raw_xmin;
    xmax  = (raw_xmax > X_HI) ? X_HI : raw_xmax;
    ymin  = (raw_ymin < ZERO) ? ZERO : raw_ymin;
    ymax  = (raw_ymax > Y_HI) ? Y_HI : raw_ymax;
    empty = (xmin > xmax) || (ymin > ymax);
  end

endmodule

// File: rtl/triangle_scan_ctrl.sv
// Accepts a triangle, registers its clipped bounding box and streams every
// pixel coordinate of the box row-major to the rasterizer.
module triangle_scan_ctrl
  import raster_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tri_valid,
  output logic                      tri_ready,
  input  logic signed [COORD_W-1:0] v1_x,
  input  logic signed [COORD_W-1:0] v1_y,
  input  logic signed [COORD_W-1:0] v2_x,
  input  logic signed [COORD_W-1:0] v2_y,
  input  logic signed [COORD_W-1:0] v3_x,
  input  logic signed [COORD_W-1:0] v3_y,
  output logic signed [COORD_W-1:0] r_v1_x,
  output logic signed [COORD_W-1:0] r_v1_y,
  output logic signed [COORD_W-1:0] r_v2_x,
  output logic signed [COORD_W-1:0] r_v2_y,
  output logic signed [COORD_W-1:0] r_v3_x,
  output logic signed [COORD_W-1:0] r_v3_y,
  output logic                      pix_valid,
  input  logic                      pix_ready,
  output logic [COORD_W-1:0]        pix_x,
  output logic [COORD_W-1:0]        pix_y,
  output logic                      pix_last,
  output logic                      busy,
  output logic                      done
);

  localparam logic signed [COORD_W-1:0] ONE = 1;

  scan_state_t state_q, state_d;
  vertex_t     rv1_q, rv1_d, rv2_q, rv2_d, rv3_q, rv3_d;
  logic signed [COORD_W-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic signed [COORD_W-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
  logic signed [COORD_W-1:0] ymax_q, ymax_d;
  logic        done_q, done_d;

  logic signed [COORD_W-1:0] bb_xmin, bb_xmax, bb_ymin, bb_ymax;
  logic        bb_empty;

  bbox_clip #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_bbox (
    .v1_x  (rv1_q.x),
    .v1_y  (rv1_q.y),
    .v2_x  (rv2_q.x),
    .v2_y  (rv2_q.y),
    .v3_x  (rv3_q.x),
    .v3_y  (rv3_q.y),
    .xmin  (bb_xmin),
    .xmax  (bb_xmax),
    .ymin  (bb_ymin),
    .ymax  (bb_ymax),
    .empty (bb_empty)
  );

  // Handshake and status outputs derived from the registered state
  always_comb begin
    tri_ready = (state_q == IDLE) && !done_q && !rst;
    pix_valid = (state_q == SCAN);
    pix_last  = (state_q == SCAN) && (pix_x_q == xmax_q) && (pix_y_q == ymax_q);
    busy      = (state_q != IDLE);
    done      = done_q;
    pix_x     = pix_x_q;
    pix_y     = pix_y_q;
    r_v1_x    = rv1_q.x;
    r_v1_y    = rv1_q.y;
    r_v2_x    = rv2_q.x;
    r_v2_y    = rv2_q.y;
    r_v3_x    = rv3_q.x;
    r_v3_y    = rv3_q.y;
  end

  // Next-state logic: accept, register the box, then walk it row-major
  always_comb begin
    state_d = state_q;
    rv1_d   = rv1_q;
    rv2_d   = rv2_q;
    rv3_d   = rv3_q;
    pix_x_d = pix_x_q;
    pix_y_d = pix_y_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymax_d  = ymax_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tri_valid && tri_ready) begin
          rv1_d   = '{x: v1_x, y: v1_y};
          rv2_d   = '{x: v2_x, y: v2_y};
          rv3_d   = '{x: v3_x, y: v3_y};
          state_d = BBOX;
        end
      end
      BBOX: begin
        xmin_d  = bb_xmin;
        xmax_d  = bb_xmax;
        ymax_d  = bb_ymax;
        pix_x_d = bb_xmin;
        pix_y_d = bb_ymin;
        if (bb_empty) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (pix_ready) begin
          if (pix_last) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (pix_x_q < xmax_q) begin
            pix_x_d = pix_x_q + ONE;
          end else begin
            pix_x_d = xmin_q;
            pix_y_d = pix_y_q + ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control, visible coordinates and latched vertices; all cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      rv1_q   <= '0;
      rv2_q   <= '0;
      rv3_q   <= '0;
      pix_x_q <= '0;
      pix_y_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      rv1_q   <= rv1_d;
      rv2_q   <= rv2_d;
      rv3_q   <= rv3_d;
      pix_x_q <= pix_x_d;
      pix_y_q <= pix_y_d;
    end
  end

  // Box limits are only read in SCAN after being loaded in BBOX, so they need no reset
  always_ff @(posedge clk) begin
    xmin_q <= xmin_d;
    xmax_q <= xmax_d;
    ymax_q <= ymax_d;
  end

endmodule

// File: tb/tb_triangle_scan_ctrl.sv
// Directed bench for triangle_scan_ctrl.
module tb_triangle_scan_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic tri_valid, tri_ready;
  logic signed [10:0] v1_x, v1_y, v2_x, v2_y, v3_x, v3_y;
  logic signed [10:0] r_v1_x, r_v1_y, r_v2_x, r_v2_y, r_v3_x, r_v3_y;
  logic pix_valid, pix_ready, pix_last, busy, done;
  logic [10:0] pix_x, pix_y;

  int n_cmp = 0;
  int n_err = 0;
  logic [65:0] ev_all;
  logic [65:0] rv_all;

  assign rv_all = {r_v1_x, r_v1_y, r_v2_x, r_v2_y, r_v3_x, r_v3_y};

  always #5 clk = ~clk;

  triangle_scan_ctrl dut (
    .clk(clk), .rst(rst), .tri_valid(tri_valid), .tri_ready(tri_ready),
    .v1_x(v1_x), .v1_y(v1_y), .v2_x(v2_x), .v2_y(v2_y), .v3_x(v3_x), .v3_y(v3_y),
    .r_v1_x(r_v1_x), .r_v1_y(r_v1_y), .r_v2_x(r_v2_x), .r_v2_y(r_v2_y),
    .r_v3_x(r_v3_x), .r_v3_y(r_v3_y),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
    .pix_last(pix_last), .busy(busy), .done(done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offer a triangle and return one cycle after it is taken (BBOX cycle)
  task automatic accept(input string nm, input int ax, ay, bx, by, cx, cy);
    int guard;
    v1_x = 11'(ax); v1_y = 11'(ay);
    v2_x = 11'(bx); v2_y = 11'(by);
    v3_x = 11'(cx); v3_y = 11'(cy);
    ev_all = {v1_x, v1_y, v2_x, v2_y, v3_x, v3_y};
    tri_valid = 1'b1;
    guard = 0;
    while (tri_ready !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    n_cmp++;
    if (tri_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s accept_timeout: tri_ready=%b required 1", nm, tri_ready);
    end
    tick();
    tri_valid = 1'b0;
    v1_x = 11'sd99; v1_y = 11'sd99; v2_x = 11'sd99;
    v2_y = 11'sd99; v3_x = 11'sd99; v3_y = 11'sd99;
    n_cmp++;
    if (rv_all !== ev_all) begin
      n_err++;
      $display("FAIL %s r_v_latch: got %h required %h", nm, rv_all, ev_all);
    end
    n_cmp++;
    if ({busy, pix_valid, tri_ready, done} !== 4'b1000) begin
      n_err++;
      $display("FAIL %s bbox_cycle: busy/pv/tr/done=%b required 1000", nm,
               {busy, pix_valid, tri_ready, done});
    end
  endtask

  // Walk the expected box from the BBOX cycle through done
  task automatic scan_box(input string nm, input int x0, x1, y0, y1, input bit stall);
    int total, beats, cyc, ph, budget;
    logic [10:0] ex, ey;
    logic exp_last;
    total = (x1 - x0 + 1) * (y1 - y0 + 1);
    budget = total * 4 + 10;
    ex = 11'(x0); ey = 11'(y0);
    beats = 0; ph = 0;
    tick();
    cyc = 2;
    while (beats < total && cyc < budget) begin
      pix_ready = stall ? ((ph % 3) == 0) : 1'b1;
      ph++;
      exp_last = (ex == 11'(x1)) && (ey == 11'(y1));
      n_cmp++;
      if (pix_valid !== 1'b1 || pix_x !== ex || pix_y !== ey || pix_last !== exp_last
          || rv_all !== ev_all) begin
        n_err++;
        $display("FAIL %s beat%0d: v=%b (%0d,%0d) last=%b required v=1 (%0d,%0d) last=%b rv_ok=%b",
                 nm, beats, pix_valid, pix_x, pix_y, pix_last, ex, ey, exp_last,
                 rv_all === ev_all);
      end else if (pix_ready) begin
        beats++;
        if (ex < 11'(x1)) ex = ex + 11'd1;
        else begin
          ex = 11'(x0);
          ey = ey + 11'd1;
        end
      end
      tick();
      cyc++;
    end
    pix_ready = 1'b1;
    n_cmp++;
    if (beats != total) begin
      n_err++;
      $display("FAIL %s beat_count: got %0d required %0d", nm, beats, total);
    end
    n_cmp++;
    if ({done, pix_valid, tri_ready, busy} !== 4'b1000) begin
      n_err++;
      $display("FAIL %s done_cycle: done/pv/tr/busy=%b required 1000", nm,
               {done, pix_valid, tri_ready, busy});
    end
    if (!stall) begin
      n_cmp++;
      if (cyc != 2 + total) begin
        n_err++;
        $display("FAIL %s done_latency: got T+%0d required T+%0d", nm, cyc, 2 + total);
      end
    end
    tick();
    n_cmp++;
    if ({done, tri_ready} !== 2'b01 || rv_all !== ev_all) begin
      n_err++;
      $display("FAIL %s after_done: done/tr=%b required 01 rv_ok=%b", nm,
               {done, tri_ready}, rv_all === ev_all);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tri_valid = 1'b0;
    pix_ready = 1'b1;
    v1_x = '0; v1_y = '0; v2_x = '0; v2_y = '0; v3_x = '0; v3_y = '0;
    tick();
    tick();
    n_cmp++;
    if ({tri_ready, pix_valid, pix_last, busy, done} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: tr/pv/last/busy/done=%b required 00000",
               {tri_ready, pix_valid, pix_last, busy, done});
    end
    n_cmp++;
    if (pix_x !== 11'd0 || pix_y !== 11'd0 || rv_all !== 66'd0) begin
      n_err++;
      $display("FAIL reset_data: pix=(%0d,%0d) rv=%h required zeros", pix_x, pix_y, rv_all);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (tri_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release: tri_ready=%b required 1", tri_ready);
    end
  endtask

  task automatic test_small;
    accept("small", 0, 0, 3, 0, 0, 3);
    scan_box("small", 0, 3, 0, 3, 1'b0);
  endtask

  task automatic test_offscreen;
    accept("offscreen", -50, -50, -10, -50, -10, -10);
    tick();
    n_cmp++;
    if ({done, pix_valid, tri_ready, busy} !== 4'b1000) begin
      n_err++;
      $display("FAIL offscreen_done: done/pv/tr/busy=%b required 1000",
               {done, pix_valid, tri_ready, busy});
    end
    tick();
    n_cmp++;
    if ({done, tri_ready, pix_valid} !== 3'b010) begin
      n_err++;
      $display("FAIL offscreen_ready: done/tr/pv=%b required 010", {done, tri_ready, pix_valid});
    end
  endtask

  task automatic test_clip_corner;
    accept("corner", 630, 470, 700, 470, 630, 500);
    scan_box("corner", 630, 639, 470, 479, 1'b0);
  endtask

  task automatic test_single;
    accept("single", 5, 5, 5, 5, 5, 5);
    scan_box("single", 5, 5, 5, 5, 1'b0);
  endtask

  task automatic test_backpressure;
    accept("stall", 2, 2, 4, 2, 3, 3);
    scan_box("stall", 2, 4, 2, 3, 1'b1);
  endtask

  task automatic test_reset_mid;
    accept("midrst", 0, 0, 3, 0, 0, 3);
    pix_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) tick();
    n_cmp++;
    if (pix_valid !== 1'b1 || pix_x !== 11'd0 || pix_y !== 11'd1) begin
      n_err++;
      $display("FAIL midrst_beat5: v=%b (%0d,%0d) required v=1 (0,1)", pix_valid, pix_x, pix_y);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({tri_ready, pix_valid, pix_last, busy, done} !== 5'b0 ||
        pix_x !== 11'd0 || pix_y !== 11'd0 || rv_all !== 66'd0) begin
      n_err++;
      $display("FAIL midrst_values: ctrl=%b pix=(%0d,%0d) rv=%h required all zero",
               {tri_ready, pix_valid, pix_last, busy, done}, pix_x, pix_y, rv_all);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({tri_ready, done, busy} !== 3'b100) begin
      n_err++;
      $display("FAIL midrst_release: tr/done/busy=%b required 100", {tri_ready, done, busy});
    end
    accept("post_rst", 1, 1, 2, 1, 1, 1);
    scan_box("post_rst", 1, 2, 1, 1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_small();
    test_offscreen();
    test_clip_corner();
    test_single();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/triangle_scan_ctrl.md
# triangle_scan_ctrl

Sequences the per-pixel triangle rasterizer: accepts one triangle (three signed vertices) per handshake, computes its screen-clipped bounding box, and streams every pixel coordinate in that box, row-major, into the rasterizer's valid/ready input. Vertices are held stable for the rasterizer for the whole scan. A one-cycle `done` pulse marks the end of each triangle. The block sits between the triangle source (setup/CPU FIFO) and the rasterizer.

## Interface
- `SCREEN_W`, 640, visible width in pixels; x range 0..SCREEN_W-1
- `SCREEN_H`, 480, visible height; y range 0..SCREEN_H-1
- `COORD_W`, 11, coordinate width; vertices are signed, pixel outputs unsigned

- `clk`  in  1  single clock; all logic on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `tri_valid`  in  1  triangle offered
- `tri_ready`  out  1  controller can accept a triangle
- `v1_x, v1_y, v2_x, v2_y, v3_x, v3_y`  in  COORD_W signed  triangle vertices, sampled on accept
- `r_v1_x … r_v3_y`  out  COORD_W signed  latched vertices driven to the rasterizer
- `pix_valid`  out  1  pixel coordinate offered to the rasterizer
- `pix_ready`  in  1  rasterizer `inReady`
- `pix_x, pix_y`  out  COORD_W  current pixel coordinate
- `pix_last`  out  1  high with the final pixel of the box
- `busy`  out  1  triangle in progress (state ≠ IDLE)
- `done`  out  1  one-cycle pulse after the last pixel is accepted, or after an empty box is detected

## Operation
- States: IDLE, BBOX, SCAN.
- IDLE: `tri_ready`=1. On `tri_valid && tri_ready`: latch the six vertices into `r_v*` → BBOX.
- BBOX (exactly one cycle): xmin = max(min(v1_x,v2_x,v3_x), 0); xmax = min(max(...), SCREEN_W-1); likewise for y with SCREEN_H-1. All comparisons signed, COORD_W bits. Register the box; load `pix_x`=xmin, `pix_y`=ymin. If xmin>xmax or ymin>ymax (triangle fully off-screen): pulse `done`, → IDLE, no pixel beats. Otherwise → SCAN.
- SCAN: `pix_valid`=1. A beat transfers on `pix_valid && pix_ready`. After a transfer: if `pix_x`<xmax, then `pix_x`+1; else `pix_x`=xmin and `pix_y`+1. `pix_last` = (`pix_x`==xmax && `pix_y`==ymax).
- Transfer with `pix_last`=1: `pix_valid` drops next cycle, `done` pulses that cycle, → IDLE.
- Degenerate triangles (collinear or single point) are scanned like any other; inside/outside is decided by the rasterizer, not here.

## Timing
- Reset (`rst`=1): state IDLE; `tri_ready`=0 while `rst` is high and 1 from the first cycle after it falls; `pix_valid`, `pix_last`, `busy`, `done`=0; `pix_x`, `pix_y`, `r_v*`=0.
- Accept at cycle T → BBOX at T+1 → first `pix_valid` at T+2 (or `done` at T+2 for an empty box).
- Throughput 1 pixel/cycle while `pix_ready`=1; box of N pixels with no backpressure: `done` at T+2+N.
- While `pix_valid && !pix_ready`: `pix_x`, `pix_y`, `pix_last` and `r_v*` hold. `pix_valid` never drops without a transfer.
- `r_v*` are stable from T+1 until the next accept; they change only on accept.
- `tri_ready`=0 in BBOX and SCAN, and in the `done` cycle. The next triangle is accepted at the earliest in the cycle after `done`.
- `rst` mid-scan: immediate return to reset values on the next edge; partial scan is abandoned, no `done`.

## Structure
- Package `raster_pkg`: `COORD_W`, screen size defaults, state enum `scan_state_t` {IDLE, BBOX, SCAN}, a vertex struct type (x,y signed COORD_W).
- Sub-module `bbox_clip`: combinational min/max of three vertices plus clip to screen, with an `empty` output. Instantiated once and registered in BBOX.

## Test plan
- (0,0),(3,0),(0,3): 16 beats (0,0),(1,0)…(3,3); `pix_last` only on (3,3); `done` at T+18 with `pix_ready`=1.
- (-50,-50),(-10,-50),(-10,-10): zero beats; `done` at T+2; `tri_ready` high at T+3.
- (630,470),(700,470),(630,500), 640×480: x 630..639, y 470..479, 100 beats; last (639,479).
- (5,5)×3: single beat (5,5) with `pix_last`=1; `done` the following cycle.
- Box (2,2)–(4,3) with `pix_ready` toggling 1,0,0,1,…: six beats in order; coordinates and `r_v*` stable across stall cycles; no beats lost or duplicated.
- `rst` pulsed at beat 5 of a 16-beat scan: all outputs at reset values next cycle, no `done`; a new triangle is accepted normally afterwards.
